// File: rtl/outp_pkg.sv
// Shared constants, types and helpers for the output peripheral bank.
// The address map is expressed as a HEX base plus per-register offsets.
package outp_pkg;

    localparam logic [11:0] HEX_BASE   = 12'h800;
    localparam logic [11:0] HEX_STRIDE = 12'h010;
    localparam logic [11:0] LEDR_OFS   = 12'h080;
    localparam logic [11:0] LEDG_OFS   = 12'h090;
    localparam logic [11:0] LCD_OFS    = 12'h0A0;
    localparam logic [11:0] STATUS_OFS = 12'h0B0;

    // LCD register: [7:0] data, [8] RS, [9] RW, [10] ON
    localparam int LCD_REG_W  = 11;
    localparam int LCD_RS_BIT = 8;
    localparam int LCD_RW_BIT = 9;
    localparam int LCD_ON_BIT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } lcd_state_e;

    // Active-low segments, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/outp_lcd_seq.sv
// LCD bus sequencer: IDLE -> SETUP -> PULSE (E high) -> HOLD -> IDLE,
// timed by one down-counter reloaded on every state entry.
module outp_lcd_seq
    import outp_pkg::*;
#(
    parameter int LCD_SETUP = 2,
    parameter int LCD_PULSE = 12,
    parameter int LCD_HOLD  = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic lcd_en_o,
    output logic busy_o
);

    localparam int CNT_W = 16;

    lcd_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_en, r_busy;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = CNT_W'(LCD_SETUP - 1);
                end
            end
            SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = CNT_W'(LCD_PULSE - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = CNT_W'(LCD_HOLD - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
        endcase
    end

    // E and busy are registered from the next state so the LCD pin never glitches on state decode.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt == PULSE);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign lcd_en_o = r_en;
    assign busy_o   = r_busy;

endmodule

// File: rtl/output_peripheral_v2.sv
// Memory-mapped HEX/LEDR/LEDG/LCD/STATUS output bank with byte-lane stores and registered read-back.
// Define OUTP_HEX_DECODE_EN to store HEX nibbles and drive hex_o through the 7-segment decoder.
module output_peripheral_v2
    import outp_pkg::*;
#(
    parameter int NUM_HEX   = 8,
    parameter int LEDR_W    = 17,
    parameter int LEDG_W    = 8,
    parameter int LCD_SETUP = 2,
    parameter int LCD_PULSE = 12,
    parameter int LCD_HOLD  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 st_en_i,
    input  logic [3:0]           st_strb_i,
    input  logic [11:0]          addr_i,
    input  logic [31:0]          st_data_i,
    output logic [31:0]          ld_data_o,
    output logic [7*NUM_HEX-1:0] hex_o,
    output logic [LEDR_W-1:0]    ledr_o,
    output logic [LEDG_W-1:0]    ledg_o,
    output logic [7:0]           lcd_data_o,
    output logic                 lcd_rs_o,
    output logic                 lcd_rw_o,
    output logic                 lcd_on_o,
    output logic                 lcd_en_o,
    output logic                 lcd_busy_o
);

`ifdef OUTP_HEX_DECODE_EN
    localparam int HEX_W = 4;
`else
    localparam int HEX_W = 7;
`endif

    logic [HEX_W-1:0]     r_hex [NUM_HEX];
    logic [LEDR_W-1:0]    r_ledr;
    logic [LEDG_W-1:0]    r_ledg;
    logic [LCD_REG_W-1:0] r_lcd;
    logic                 r_overrun;

    logic [NUM_HEX-1:0] w_hex_sel;
    logic               w_ledr_sel, w_ledg_sel, w_lcd_sel, w_stat_sel;
    logic               w_busy, w_lcd_hit, w_lcd_start, w_ovr_set, w_ovr_clr;
    logic [31:0]        w_ledr_wr, w_ledg_wr, w_lcd_wr, w_rdata;
    logic               w_unused;

    for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
        assign w_hex_sel[gi] = (addr_i == HEX_BASE + HEX_STRIDE * 12'(gi));
`ifdef OUTP_HEX_DECODE_EN
        assign hex_o[7*gi +: 7] = seg7_decode(r_hex[gi]);
`else
        assign hex_o[7*gi +: 7] = r_hex[gi];
`endif
    end

    assign w_ledr_sel = (addr_i == HEX_BASE + LEDR_OFS);
    assign w_ledg_sel = (addr_i == HEX_BASE + LEDG_OFS);
    assign w_lcd_sel  = (addr_i == HEX_BASE + LCD_OFS);
    assign w_stat_sel = (addr_i == HEX_BASE + STATUS_OFS);

    assign w_ledr_wr = lane_merge(32'(r_ledr), st_data_i, st_strb_i);
    assign w_ledg_wr = lane_merge(32'(r_ledg), st_data_i, st_strb_i);
    assign w_lcd_wr  = lane_merge(32'(r_lcd), st_data_i, st_strb_i);

    // LCD stores only land when the sequencer is idle; anything arriving while busy flags overrun.
    assign w_lcd_hit   = st_en_i && w_lcd_sel;
    assign w_lcd_start = w_lcd_hit && (|st_strb_i) && !w_busy;
    assign w_ovr_set   = w_lcd_hit && w_busy;
    assign w_ovr_clr   = st_en_i && w_stat_sel && st_strb_i[0] && st_data_i[1];

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (w_hex_sel[i]) w_rdata = 32'(r_hex[i]);
        end
        if (w_ledr_sel) w_rdata = 32'(r_ledr);
        if (w_ledg_sel) w_rdata = 32'(r_ledg);
        if (w_lcd_sel)  w_rdata = 32'(r_lcd);
        if (w_stat_sel) w_rdata = {30'd0, r_overrun, w_busy};
    end

    // NOTE: the HEX array is a handful of output registers, so every entry gets a reset value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_HEX; i++) r_hex[i] <= '0;
            r_ledr    <= '0;
            r_ledg    <= '0;
            r_lcd     <= '0;
            r_overrun <= 1'b0;
            ld_data_o <= '0;
        end else begin
            for (int i = 0; i < NUM_HEX; i++) begin
                if (st_en_i && w_hex_sel[i] && st_strb_i[0]) r_hex[i] <= st_data_i[HEX_W-1:0];
            end
            if (st_en_i && w_ledr_sel) r_ledr <= w_ledr_wr[LEDR_W-1:0];
            if (st_en_i && w_ledg_sel) r_ledg <= w_ledg_wr[LEDG_W-1:0];
            if (w_lcd_start)           r_lcd  <= w_lcd_wr[LCD_REG_W-1:0];
            if (w_ovr_set)             r_overrun <= 1'b1;
            else if (w_ovr_clr)        r_overrun <= 1'b0;
            ld_data_o <= w_rdata;
        end
    end

    outp_lcd_seq #(
        .LCD_SETUP(LCD_SETUP),
        .LCD_PULSE(LCD_PULSE),
        .LCD_HOLD (LCD_HOLD)
    ) u_lcd_seq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (w_lcd_start),
        .lcd_en_o(lcd_en_o),
        .busy_o  (w_busy)
    );

    assign ledr_o     = r_ledr;
    assign ledg_o     = r_ledg;
    assign lcd_data_o = r_lcd[7:0];
    assign lcd_rs_o   = r_lcd[LCD_RS_BIT];
    assign lcd_rw_o   = r_lcd[LCD_RW_BIT];
    assign lcd_on_o   = r_lcd[LCD_ON_BIT];
    assign lcd_busy_o = w_busy;

    // Store-word bits above each register's width are intentionally dropped.
    assign w_unused = ^{1'b0, w_ledr_wr, w_ledg_wr, w_lcd_wr, st_data_i};

endmodule

// File: tb/tb_output_peripheral_v2.sv
// Self-checking bench for output_peripheral_v2 (NUM_HEX=4); loads are scoreboarded through a queue.
// Builds with or without OUTP_HEX_DECODE_EN.
module tb_output_peripheral_v2;

    localparam int NUM_HEX = 4;
    localparam int LEDR_W  = 17;
    localparam int LEDG_W  = 8;

    localparam logic [11:0] A_LEDR = 12'h880;
    localparam logic [11:0] A_LEDG = 12'h890;
    localparam logic [11:0] A_LCD  = 12'h8A0;
    localparam logic [11:0] A_STAT = 12'h8B0;

`ifdef OUTP_HEX_DECODE_EN
    localparam logic [6:0]  H_0    = 7'h40;
    localparam logic [6:0]  HX_CH0 = 7'h08;
    localparam logic [6:0]  HX_CH3 = 7'h0E;
    localparam logic [31:0] RD_CH0 = 32'hA;
    localparam logic [31:0] RD_CH3 = 32'hF;
`else
    localparam logic [6:0]  H_0    = 7'h00;
    localparam logic [6:0]  HX_CH0 = 7'h1A;
    localparam logic [6:0]  HX_CH3 = 7'h7F;
    localparam logic [31:0] RD_CH0 = 32'h1A;
    localparam logic [31:0] RD_CH3 = 32'h7F;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 st_en_i;
    logic [3:0]           st_strb_i;
    logic [11:0]          addr_i;
    logic [31:0]          st_data_i;
    logic [31:0]          ld_data_o;
    logic [7*NUM_HEX-1:0] hex_o;
    logic [LEDR_W-1:0]    ledr_o;
    logic [LEDG_W-1:0]    ledg_o;
    logic [7:0]           lcd_data_o;
    logic                 lcd_rs_o, lcd_rw_o, lcd_on_o, lcd_en_o, lcd_busy_o;

    int          vectors = 0;
    int          miscompares = 0;
    bit          ld_issue = 1'b0;
    logic [31:0] exp_q [$];
    logic [11:0] addr_q [$];

    output_peripheral_v2 #(
        .NUM_HEX(NUM_HEX),
        .LEDR_W (LEDR_W),
        .LEDG_W (LEDG_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .st_en_i   (st_en_i),
        .st_strb_i (st_strb_i),
        .addr_i    (addr_i),
        .st_data_i (st_data_i),
        .ld_data_o (ld_data_o),
        .hex_o     (hex_o),
        .ledr_o    (ledr_o),
        .ledg_o    (ledg_o),
        .lcd_data_o(lcd_data_o),
        .lcd_rs_o  (lcd_rs_o),
        .lcd_rw_o  (lcd_rw_o),
        .lcd_on_o  (lcd_on_o),
        .lcd_en_o  (lcd_en_o),
        .lcd_busy_o(lcd_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Load monitor: a load issued at an edge is compared 1 ns after that edge.
    always @(posedge clk_i) begin
        if (ld_issue) begin
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL load_scoreboard: got %h with no expected entry", ld_data_o);
            end else begin
                logic [31:0] exp_v;
                logic [11:0] a_v;
                exp_v = exp_q.pop_front();
                a_v   = addr_q.pop_front();
                if (ld_data_o !== exp_v) begin
                    miscompares++;
                    $display("FAIL load@%h: got %h want %h", a_v, ld_data_o, exp_v);
                end
            end
        end
    end

    // Drive one cycle of stimulus at a negedge and wait for the following negedge.
    task automatic cyc(input logic en, input logic [3:0] strb, input logic [11:0] addr,
                       input logic [31:0] data, input bit ld, input logic [31:0] exp_v);
        st_en_i   = en;
        st_strb_i = strb;
        addr_i    = addr;
        st_data_i = data;
        ld_issue  = ld;
        if (ld) begin
            exp_q.push_back(exp_v);
            addr_q.push_back(addr);
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic load(input logic [11:0] addr, input logic [31:0] exp_v);
        cyc(1'b0, 4'h0, addr, 32'h0, 1'b1, exp_v);
    endtask

    task automatic test_reset();
        logic [11:0] addrs [12];
        rst_ni = 1'b0;
        st_en_i = 1'b0; st_strb_i = '0; addr_i = '0; st_data_i = '0; ld_issue = 1'b0;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({ld_data_o, lcd_en_o, lcd_busy_o, ledr_o, ledg_o, lcd_data_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ld=%h en=%b busy=%b ledr=%h ledg=%h lcd=%h want all 0",
                     ld_data_o, lcd_en_o, lcd_busy_o, ledr_o, ledg_o, lcd_data_o);
        end
        vectors++;
        if (hex_o !== {NUM_HEX{H_0}}) begin
            miscompares++;
            $display("FAIL reset_hex: got %h want %h", hex_o, {NUM_HEX{H_0}});
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 8; i++) addrs[i] = 12'h800 + 12'(16 * i);
        addrs[8] = A_LEDR; addrs[9] = A_LEDG; addrs[10] = A_LCD; addrs[11] = A_STAT;
        for (int i = 0; i < 12; i++) load(addrs[i], 32'h0);
    endtask

    task automatic test_led_strobe();
        cyc(1'b1, 4'b0011, A_LEDR, 32'hDEADBEEF, 1'b0, 32'h0);
        vectors++;
        if (ledr_o !== 17'h0BEEF) begin
            miscompares++;
            $display("FAIL ledr_lanes01: got %h want %h", ledr_o, 17'h0BEEF);
        end
        load(A_LEDR, 32'h0000BEEF);
        cyc(1'b1, 4'b1100, A_LEDR, 32'hFFFFFFFF, 1'b0, 32'h0);
        vectors++;
        if (ledr_o !== 17'h1BEEF) begin
            miscompares++;
            $display("FAIL ledr_lanes23: got %h want %h", ledr_o, 17'h1BEEF);
        end
        load(A_LEDR, 32'h0001BEEF);
        cyc(1'b1, 4'b1111, A_LEDG, 32'h12345678, 1'b0, 32'h0);
        vectors++;
        if (ledg_o !== 8'h78) begin
            miscompares++;
            $display("FAIL ledg_store: got %h want %h", ledg_o, 8'h78);
        end
        load(A_LEDG, 32'h78);
    endtask

    task automatic test_hex();
        logic [7*NUM_HEX-1:0] exp_hex;
        cyc(1'b1, 4'b0001, 12'h800, 32'h0000001A, 1'b0, 32'h0);
        vectors++;
        if (hex_o[6:0] !== HX_CH0) begin
            miscompares++;
            $display("FAIL hex_ch0: got %h want %h", hex_o[6:0], HX_CH0);
        end
        cyc(1'b1, 4'b0001, 12'h830, 32'h0000007F, 1'b0, 32'h0);
        cyc(1'b1, 4'b0010, 12'h810, 32'h00005555, 1'b0, 32'h0);
        cyc(1'b1, 4'b1111, 12'h840, 32'h0000007F, 1'b0, 32'h0);
        exp_hex = {HX_CH3, H_0, H_0, HX_CH0};
        vectors++;
        if (hex_o !== exp_hex) begin
            miscompares++;
            $display("FAIL hex_all: got %h want %h", hex_o, exp_hex);
        end
        load(12'h800, RD_CH0);
        load(12'h810, 32'h0);
        load(12'h830, RD_CH3);
        load(12'h840, 32'h0);
        load(12'h870, 32'h0);
    endtask

    // Store and load to the same address in one cycle returns the pre-store value.
    task automatic test_back_to_back();
        cyc(1'b1, 4'b0001, A_LEDG, 32'h11, 1'b1, 32'h78);
        cyc(1'b1, 4'b0001, A_LEDG, 32'h22, 1'b1, 32'h11);
        load(A_LEDG, 32'h22);
    endtask

    task automatic test_lcd();
        logic exp_en, exp_busy;
        int   n;
        for (int k = 0; k <= 16; k++) begin
            case (k)
                0:       cyc(1'b1, 4'b0011, A_LCD, 32'h5A5, 1'b0, 32'h0);
                5:       cyc(1'b1, 4'b0011, A_LCD, 32'h3FF, 1'b0, 32'h0);
                6:       load(A_STAT, 32'h3);
                7:       cyc(1'b1, 4'b0001, A_STAT, 32'h2, 1'b0, 32'h0);
                8:       load(A_STAT, 32'h1);
                9:       load(A_LCD, 32'h5A5);
                default: idle();
            endcase
            exp_en   = (k >= 2) && (k <= 13);
            exp_busy = (k <= 15);
            vectors++;
            if (lcd_en_o !== exp_en || lcd_busy_o !== exp_busy) begin
                miscompares++;
                $display("FAIL lcd_timing_t+%0d: en=%b busy=%b want en=%b busy=%b",
                         k, lcd_en_o, lcd_busy_o, exp_en, exp_busy);
            end
            vectors++;
            if ({lcd_on_o, lcd_rw_o, lcd_rs_o, lcd_data_o} !== 11'h5A5) begin
                miscompares++;
                $display("FAIL lcd_bus_t+%0d: got %h want %h",
                         k, {lcd_on_o, lcd_rw_o, lcd_rs_o, lcd_data_o}, 11'h5A5);
            end
        end
        cyc(1'b1, 4'b0001, A_LCD, 32'hFF, 1'b0, 32'h0);
        vectors++;
        if (lcd_busy_o !== 1'b1 || lcd_data_o !== 8'hFF || lcd_rs_o !== 1'b1) begin
            miscompares++;
            $display("FAIL lcd_restart: busy=%b data=%h rs=%b want 1 ff 1",
                     lcd_busy_o, lcd_data_o, lcd_rs_o);
        end
        n = 0;
        while (lcd_busy_o && n < 40) begin
            idle();
            n++;
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL lcd_busy_len: busy cleared after %0d more cycles want 16", n);
        end
        load(A_STAT, 32'h0);
    endtask

    task automatic test_async_reset();
        int n;
        cyc(1'b1, 4'b0011, A_LCD, 32'h401, 1'b0, 32'h0);
        n = 0;
        while (!lcd_en_o && n < 10) begin
            idle();
            n++;
        end
        vectors++;
        if (lcd_en_o !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reach_pulse: en=%b want 1", lcd_en_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (lcd_en_o !== 1'b0 || lcd_busy_o !== 1'b0 || lcd_on_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: en=%b busy=%b on=%b want 0 0 0",
                     lcd_en_o, lcd_busy_o, lcd_on_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
        load(A_STAT, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_led_strobe();
        test_hex();
        test_back_to_back();
        test_lcd();
        test_async_reset();
        idle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL load_queue_drain: %0d loads never observed want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_peripheral_v2.md
# output_peripheral_v2

Parametrised memory-mapped output bank on the MEM-stage store/load bus. It is the successor to the fixed HEX/LEDR/LEDG/LCD register bank, and adds the following:
- Configurable HEX channel count and LED widths.
- Byte-lane store strobes.
- Registered read-back.
- A timed LCD bus sequencer that generates the E strobe, with a status register.

## Interface
Parameters:
- NUM_HEX, 8: HEX channels, 1..8, at 0x800 + 0x10·i
- LEDR_W, 17: red LED width, 1..32
- LEDG_W, 8: green LED width, 1..32
- LCD_SETUP, 2: cycles with RS/RW/data valid before E rises, ≥1
- LCD_PULSE, 12: E high cycles, ≥1
- LCD_HOLD, 2: cycles after E falls before the next command, ≥1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- st_en_i  in  1  store valid
- st_strb_i  in  4  byte-lane strobes; lane b covers bits 8b+7:8b
- addr_i  in  12  word address, shared by store and load
- st_data_i  in  32  store data
- ld_data_o  out  32  registered read-back
- hex_o  out  7·NUM_HEX  segments; channel i at bits 7i+6:7i
- ledr_o  out  LEDR_W  red LEDs
- ledg_o  out  LEDG_W  green LEDs
- lcd_data_o  out  8  LCD data bus
- lcd_rs_o, lcd_rw_o, lcd_on_o, lcd_en_o  out  1 each  LCD control
- lcd_busy_o  out  1  sequencer active

## Operation
- Map:
  - HEX i at 0x800+0x10·i
  - LEDR at 0x880
  - LEDG at 0x890
  - LCD at 0x8A0
  - STATUS at 0x8B0
- Any other address, or HEX i with i ≥ NUM_HEX, is unmapped: stores are ignored and reads return 0.
- Store: at a posedge with st_en_i, each lane with its strobe set is written; other lanes keep their value. Unused bits are not stored and read back as 0.
- LCD register layout: [7:0] data, [8] RS, [9] RW, [10] ON.
- An accepted LCD store requires at least one strobe set and the sequencer in IDLE.
- An LCD store while busy is dropped and sets STATUS[1].
- LCD FSM: IDLE → SETUP (LCD_SETUP cycles) → PULSE (LCD_PULSE cycles, lcd_en_o=1) → HOLD (LCD_HOLD cycles) → IDLE. One down-counter, reloaded on each state entry.
- lcd_data_o, lcd_rs_o, lcd_rw_o and lcd_on_o follow the LCD register continuously. Because stores are dropped while busy, they are stable for the whole sequence.
- STATUS layout:
  - [0] busy, read-only
  - [1] overrun, sticky; cleared by a store with bit1=1 and strobe[0] set
  - A set and a clear in the same cycle: set wins.
- Read-back: ld_data_o is registered from addr_i each cycle. A simultaneous store to the same address returns the pre-store value.

## Timing
- Reset values: every register, ld_data_o, lcd_en_o and lcd_busy_o are 0; the FSM is in IDLE. hex_o follows the Configuration rules.
- Reset asserted mid-sequence forces IDLE and lcd_en_o=0 immediately (asynchronous).
- An LCD store accepted at edge t:
  - Register, outputs and busy update after edge t.
  - lcd_en_o is high for edges t+LCD_SETUP .. t+LCD_SETUP+LCD_PULSE−1.
  - busy falls after edge t+LCD_SETUP+LCD_PULSE+LCD_HOLD.
- The next accepted LCD store is the one whose edge sees busy=0.
- Store to other registers: the output changes one cycle after the edge.
- Load latency: 1 cycle.

## Configuration
- OUTP_HEX_DECODE_EN defined:
  - The HEX register stores bits [3:0] only.
  - hex_o is the active-low 7-segment decode of that nibble: 0→1000000, A→0001000, F→0001110.
  - Reset shows 1000000 on every channel.
- OUTP_HEX_DECODE_EN undefined:
  - The HEX register stores [6:0].
  - hex_o is those raw bits; reset value 0.

## Structure
- Package outp_pkg holds:
  - Address constants: HEX_BASE, HEX_STRIDE, LEDR/LEDG/LCD/STATUS offsets.
  - LCD register bit positions.
  - lcd_state_e enum: IDLE/SETUP/PULSE/HOLD.
  - seg7_decode function.
- Sub-module outp_lcd_seq contains the FSM, counter and busy logic. It takes a start pulse and produces lcd_en_o and busy.

## Test plan
- Reset, then read all addresses → all 0; hex_o per macro.
- Store 0xDEADBEEF to LEDR with strb=0b0011 → reg 0xBEEF; LEDR_W=17 read-back 0x0BEEF.
- LCD store 0x5A5 (data 0xA5, RS=1, ON=1) with defaults → lcd_en_o high edges t+2..t+13; busy clears after t+16.
- Second LCD store at t+5 → dropped, lcd_data_o stays 0xA5, STATUS reads 0x3; store 0x2 to STATUS → reads 0x1 while busy.
- Assert rst_ni during PULSE → lcd_en_o and busy drop without waiting for a clock edge.
- NUM_HEX=4: store to 0x840 → no output change; read returns 0.
